// File: rtl/packet_sequencer.sv
// packet_sequencer: sequences decode, encryption, CRC and USB transmit for each received packet.
// Defining PACKET_SEQ_STATS_EN adds saturating pkt_cnt/drop_cnt statistics outputs.
module packet_sequencer #(
    parameter int unsigned ENC_LAT     = 16,
    parameter int unsigned CRC_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       eop_found,
    input  logic [2:0] data_select,
    input  logic       keys_valid,
    input  logic       crc_done,
    input  logic       tx_busy,
    output logic       enc_start,
    output logic       crc_start,
    output logic       read_ready,
    output logic       busy,
`ifdef PACKET_SEQ_STATS_EN
    output logic       overrun,
    output logic [7:0] pkt_cnt,
    output logic [7:0] drop_cnt
`else
    output logic       overrun
`endif
);
    typedef enum logic [2:0] {IDLE, DECODE, ENCRYPT, CRC, WAIT_TX, SEND} state_t;
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    state_d = eop_found ? DECODE : IDLE;
            DECODE: begin
                if (data_select == 3'b000) begin
                    state_d = IDLE;
                end else if (data_select[2:1] == 2'b01) begin
                    state_d = keys_valid ? ENCRYPT : IDLE;
                    cnt_d   = 8'(ENC_LAT - 1);
                end else begin
                    state_d = WAIT_TX;
                end
            end
            ENCRYPT: begin
                if (cnt_q == 8'd0) begin
                    state_d = CRC;
                    cnt_d   = 8'(CRC_TIMEOUT - 1);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            // crc_done wins over a timeout landing in the same cycle
            CRC: begin
                if (crc_done) begin
                    state_d = WAIT_TX;
                    cnt_d   = 8'd0;
                end else if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            WAIT_TX: state_d = tx_busy ? WAIT_TX : SEND;
            SEND:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // Strobes are decoded from the upcoming transition so they land in the first cycle of each state
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            enc_start  <= 1'b0;
            crc_start  <= 1'b0;
            read_ready <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            enc_start  <= (state_q == DECODE) && (state_d == ENCRYPT);
            crc_start  <= (state_q == ENCRYPT) && (state_d == CRC);
            read_ready <= state_d == SEND;
            busy       <= state_d != IDLE;
            overrun    <= overrun | (eop_found && state_q != IDLE);
        end
    end
`ifdef PACKET_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pkt_cnt  <= 8'd0;
            drop_cnt <= 8'd0;
        end else begin
            if (state_q == SEND && pkt_cnt != 8'hFF)
                pkt_cnt <= pkt_cnt + 8'd1;
            if ((state_q == DECODE || state_q == CRC) && state_d == IDLE && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_packet_sequencer.sv
// tb_packet_sequencer: directed bench for packet_sequencer; cycle numbers follow "eop sampled at edge N".
module tb_packet_sequencer;
    logic       clk = 1'b0;
    logic       n_rst, eop_found, keys_valid, crc_done, tx_busy;
    logic [2:0] data_select;
    logic       enc_start, crc_start, read_ready, busy, overrun;
`ifdef PACKET_SEQ_STATS_EN
    logic [7:0] pkt_cnt, drop_cnt;
`endif
    int checks = 0, errors = 0;
    int ecnt = 0;
    int n_enc, n_crc, n_rr, n_multi, enc_cyc, crc_cyc, rr_cyc;
    int n;

    packet_sequencer dut (
        .clk(clk), .n_rst(n_rst), .eop_found(eop_found), .data_select(data_select),
        .keys_valid(keys_valid), .crc_done(crc_done), .tx_busy(tx_busy),
        .enc_start(enc_start), .crc_start(crc_start), .read_ready(read_ready),
`ifdef PACKET_SEQ_STATS_EN
        .busy(busy), .overrun(overrun), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`else
        .busy(busy), .overrun(overrun)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    // Output seen after edge M belongs to cycle M+1
    always @(negedge clk) begin
        if (enc_start) begin n_enc++; enc_cyc = ecnt + 1; end
        if (crc_start) begin n_crc++; crc_cyc = ecnt + 1; end
        if (read_ready) begin n_rr++; rr_cyc = ecnt + 1; end
        if (int'(enc_start) + int'(crc_start) + int'(read_ready) > 1) n_multi++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (ecnt < t) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_eop(input logic [2:0] ds, output int edge_n);
        n_enc = 0; n_crc = 0; n_rr = 0;
        enc_cyc = -1; crc_cyc = -1; rr_cyc = -1;
        data_select = ds;
        eop_found   = 1'b1;
        tick();
        edge_n    = ecnt;
        eop_found = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; eop_found = 1'b0; keys_valid = 1'b1; crc_done = 1'b0;
        tx_busy = 1'b0; data_select = 3'b000; n_multi = 0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_pulses", {enc_start, crc_start, read_ready}, 0);
        n_rst = 1'b1;
        tick();

        // passthrough
        send_eop(3'b001, n);
        check("pass_busy_decode", busy, 1);
        wait_until(n + 6);
        check("pass_rr_cycle", rr_cyc, n + 3);
        check("pass_rr_count", n_rr, 1);
        check("pass_no_enc_crc", n_enc + n_crc, 0);
        check("pass_idle", busy, 0);

        // encrypted packet, keys drop mid-encrypt must not abort
        send_eop(3'b010, n);
        wait_until(n + 5);
        keys_valid = 1'b0;
        wait_until(n + 20);
        crc_done = 1'b1;
        tick();
        crc_done = 1'b0;
        wait_until(n + 26);
        keys_valid = 1'b1;
        check("enc_start_cycle", enc_cyc, n + 2);
        check("crc_start_cycle", crc_cyc, n + 18);
        check("enc_rr_cycle", rr_cyc, n + 23);
        check("enc_counts", {8'(n_enc), 8'(n_crc), 8'(n_rr)}, 32'h010101);

        // drops
        keys_valid = 1'b0;
        send_eop(3'b011, n);
        wait_until(n + 4);
        check("drop_nokeys_pulses", n_enc + n_crc + n_rr, 0);
        check("drop_nokeys_idle", busy, 0);
        keys_valid = 1'b1;
        send_eop(3'b000, n);
        wait_until(n + 4);
        check("drop_null_pulses", n_enc + n_crc + n_rr, 0);
        check("drop_null_idle", busy, 0);
        check("drop_no_overrun", overrun, 0);
`ifdef PACKET_SEQ_STATS_EN
        check("stats_drop2", drop_cnt, 2);
        check("stats_pkt2", pkt_cnt, 2);
`endif

        // CRC timeout plus overrun from an eop during ENCRYPT
        send_eop(3'b011, n);
        wait_until(n + 4);
        eop_found = 1'b1;
        tick();
        eop_found = 1'b0;
        check("ovr_set", overrun, 1);
        check("ovr_still_busy", busy, 1);
        wait_until(n + 271);
        check("tmo_busy_last", busy, 1);
        tick();
        check("tmo_idle", busy, 0);
        check("tmo_counts", {8'(n_enc), 8'(n_crc), 8'(n_rr)}, 32'h010100);
        wait_until(n + 275);
        check("tmo_no_rr", n_rr, 0);

        // tx_busy back-pressure
        tx_busy = 1'b1;
        send_eop(3'b100, n);
        wait_until(n + 9);
        tx_busy = 1'b0;
        wait_until(n + 14);
        check("txb_rr_cycle", rr_cyc, n + 11);
        check("txb_rr_count", n_rr, 1);
        check("ovr_sticky", overrun, 1);
`ifdef PACKET_SEQ_STATS_EN
        check("stats_drop3", drop_cnt, 3);
        check("stats_pkt3", pkt_cnt, 3);
`endif

        // reset during ENCRYPT
        send_eop(3'b010, n);
        wait_until(n + 6);
        n_rst = 1'b0;
        tick();
        check("mrst_busy", busy, 0);
        check("mrst_overrun", overrun, 0);
        n_rst = 1'b1;
        wait_until(n + 30);
        check("mrst_no_crc_rr", n_crc + n_rr, 0);
        check("mrst_enc_once", n_enc, 1);
        check("mrst_idle", busy, 0);
`ifdef PACKET_SEQ_STATS_EN
        check("stats_rst", {pkt_cnt, drop_cnt}, 0);
`endif

        // eop coinciding with SEND
        send_eop(3'b111, n);
        wait_until(n + 2);
        eop_found = 1'b1;
        tick();
        eop_found = 1'b0;
        check("coin_overrun", overrun, 1);
        check("coin_no_restart", busy, 0);
        tick();
        check("coin_still_idle", busy, 0);
        check("coin_rr_cycle", rr_cyc, n + 3);
`ifdef PACKET_SEQ_STATS_EN
        check("stats_pkt1", pkt_cnt, 1);
`endif
        check("one_hot_strobes", n_multi, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/packet_sequencer.md
PACKET_SEQUENCER -- requirements
Module: packet_sequencer

Interface
REQ-001 SHALL have parameter ENC_LAT, default 16, giving the fixed encryption latency in cycles from enc_start to valid encrypted data (legal 1..255).
REQ-002 SHALL have parameter CRC_TIMEOUT, default 255, giving the maximum cycles to wait for crc_done (legal 1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port n_rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port eop_found, input, 1 bit: one-cycle pulse from the USB reader when a packet's EOP is detected.
REQ-006 SHALL have port data_select, input, 3 bits: the packet class from the PID checker, sampled in DECODE.
REQ-007 SHALL have port keys_valid, input, 1 bit: high when all 16 SPI round keys are loaded.
REQ-008 SHALL have port crc_done, input, 1 bit: the CRC16 calculator has finished.
REQ-009 SHALL have port tx_busy, input, 1 bit: the USB writer is still shifting out the previous packet.
REQ-010 SHALL have port enc_start, output, 1 bit: one-cycle start pulse to the encryption core.
REQ-011 SHALL have port crc_start, output, 1 bit: one-cycle start pulse to the CRC16 calculator.
REQ-012 SHALL have port read_ready, output, 1 bit: one-cycle load pulse to the USB writer.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 SHALL have port overrun, output, 1 bit: sticky flag, set when eop_found arrives while busy.

Function
REQ-015 SHALL implement a state machine with states IDLE, DECODE, ENCRYPT, CRC, WAIT_TX and SEND, all outputs registered.
REQ-016 IDLE SHALL go to DECODE on eop_found and otherwise stay in IDLE.
REQ-017 DECODE SHALL last 1 cycle and branch on data_select: 3'b000 drops the packet to IDLE; 3'b010 or 3'b011 (DATA0/DATA1) goes to ENCRYPT if keys_valid, else drops to IDLE; any other value goes to WAIT_TX as passthrough.
REQ-018 ENCRYPT SHALL last exactly ENC_LAT cycles, using an 8-bit down-counter, with enc_start high only in its first cycle, then go to CRC.
REQ-019 CRC SHALL hold crc_start high only in its first cycle, go to WAIT_TX in the cycle after crc_done is sampled high, and drop to IDLE after CRC_TIMEOUT cycles without crc_done.
REQ-020 WAIT_TX SHALL go to SEND in the first cycle that tx_busy is sampled low.
REQ-021 SEND SHALL last 1 cycle with read_ready high, then go to IDLE.
REQ-022 For a passthrough packet with tx_busy low, an eop_found sampled at edge N SHALL produce read_ready high in cycle N+3.
REQ-023 For an encrypted packet with ENC_LAT=16, an eop_found sampled at edge N SHALL produce enc_start in cycle N+2 and crc_start in cycle N+18.
REQ-024 An eop_found arriving while not in IDLE SHALL be ignored for sequencing and SHALL set overrun, which clears only on reset.
REQ-025 If eop_found and the final SEND cycle coincide, the eop_found SHALL count as an overrun and SHALL NOT start a new packet.
REQ-026 A keys_valid deassertion during ENCRYPT or CRC SHALL NOT abort the packet in progress.
REQ-027 At most one of enc_start, crc_start and read_ready SHALL be high in any cycle.

Reset
REQ-028 n_rst low at a clock edge SHALL force state IDLE and set enc_start, crc_start, read_ready, busy and overrun to 0, and all counters to 0, including mid-operation.
REQ-029 Pulses interrupted by reset SHALL NOT be re-issued after reset.

Configuration
REQ-030 With macro PACKET_SEQ_STATS_EN defined, the block SHALL add 8-bit outputs pkt_cnt and drop_cnt, both reset to 0 and saturating at 255.
REQ-031 Under PACKET_SEQ_STATS_EN, pkt_cnt SHALL increment in SEND, and drop_cnt SHALL increment on every DECODE drop and every CRC timeout.
REQ-032 Without PACKET_SEQ_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Bench SHALL cover: data_select=3'b001, tx_busy=0, eop_found at edge N -> read_ready single pulse in cycle N+3, no enc_start and no crc_start.
REQ-034 Bench SHALL cover: data_select=3'b010, keys_valid=1, crc_done 3 cycles after crc_start -> enc_start at N+2, crc_start at N+18, read_ready at N+23.
REQ-035 Bench SHALL cover: data_select=3'b011 with keys_valid=0, then data_select=3'b000 -> no pulses and return to IDLE; with stats enabled, drop_cnt=2.
REQ-036 Bench SHALL cover: crc_done never asserted -> return to IDLE after 255 CRC cycles with no read_ready; a second eop_found during ENCRYPT -> overrun=1.
REQ-037 Bench SHALL cover: tx_busy held high for 10 cycles -> read_ready in the cycle after tx_busy falls.
REQ-038 Bench SHALL cover: n_rst low during ENCRYPT -> busy=0 on the next cycle and no crc_start afterwards.
